// File: rtl/ifetch_queue_if.sv
// Bundle of the fetch queue's memory, redirect and decode-side signals.
// Handshake: an entry moves to decode in every cycle where out_valid and
// out_ready are both high at the rising clock edge; out_valid never depends
// on out_ready, and the entry stays stable until it is taken or flushed.
interface ifetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic          imem_rd;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;

    // Fetch queue side
    modport master (
        output imem_addr, imem_rd, out_valid, out_instr, out_pc, count,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    // Memory / decode / branch-unit side
    modport slave (
        input  imem_addr, imem_rd, out_valid, out_instr, out_pc, count,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential PC generation, one outstanding
// request to a synchronous instruction memory, and a small FIFO of
// {pc, instr} entries handed to decode. A redirect flushes everything and
// restarts fetch at the target.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];

    logic [AW+1:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic [31:0]   target_pc;

    // Issue only when the outstanding response is guaranteed a free slot,
    // so a returning word can never be dropped for lack of space.
    always_comb begin
        occupancy = {1'b0, count_q} + {{(AW + 1){1'b0}}, inflight};
        issue     = rst & ~bus.redirect & (occupancy < (AW + 2)'(DEPTH));
        push      = inflight & ~bus.redirect;
        pop       = (count_q != '0) & bus.out_ready & ~bus.redirect;
        target_pc = bus.redirect_pc & 32'hFFFF_FFFC;
    end

    // Drive memory request and decode-side outputs straight from state.
    always_comb begin
        bus.imem_rd   = issue;
        bus.imem_addr = fetch_pc;
        bus.out_valid = (count_q != '0);
        bus.out_instr = mem_instr[rd_ptr];
        bus.out_pc    = mem_pc[rd_ptr];
        bus.count     = count_q;
    end

    // PC generation and the single outstanding-request tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= target_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.redirect) begin
            rd_ptr  <= wr_ptr;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios followed by random
// out_ready/redirect traffic, scored against a queue-level reference model.
module tb_ifetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: word at index i is 32'h1000_0000 + i
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 + {22'd0, a[11:2]};
    endfunction

    // Synchronous instruction memory
    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_rdata <= word_at(bus.imem_addr);
    end

    // Reference model: expected FIFO contents {pc, instr}, one outstanding fetch
    logic [63:0] exp_q[$];
    logic        m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_fetch_pc;

    // Observations of what the DUT actually delivered / requested
    logic [31:0] obs_pop_q[$];
    logic [31:0] obs_req_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        if (obs_pop_q.size() > i) return obs_pop_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (obs_req_q.size() > i) return obs_req_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    // One clock: check outputs mid-cycle against the model, then step the model
    task automatic cycle();
        logic rd_e;
        @(negedge clk);
        rd_e = !bus.redirect && ((exp_q.size() + int'(m_inflight)) < DEPTH);
        chk("imem_rd", bus.imem_rd, rd_e);
        if (rd_e) chk("imem_addr", bus.imem_addr, m_fetch_pc);
        chk("count", bus.count, exp_q.size());
        chk("count_le_depth", bus.count <= DEPTH, 1);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("out_pc", bus.out_pc, exp_q[0][63:32]);
            chk("out_instr", bus.out_instr, exp_q[0][31:0]);
        end
        if (bus.out_valid && bus.out_ready && !bus.redirect) obs_pop_q.push_back(bus.out_pc);
        if (bus.imem_rd) obs_req_q.push_back(bus.imem_addr);
        if (bus.redirect) begin
            exp_q.delete();
            m_inflight = 1'b0;
            m_fetch_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
            if (m_inflight) exp_q.push_back({m_inflight_pc, word_at(m_inflight_pc)});
            if (rd_e) begin
                m_inflight_pc = m_fetch_pc;
                m_fetch_pc    = m_fetch_pc + 32'd4;
                m_inflight    = 1'b1;
            end else begin
                m_inflight = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic do_reset(input logic ready);
        rst = 1'b0;
        #1;
        chk("rst_imem_rd", bus.imem_rd, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_pc", bus.out_pc, 0);
        exp_q.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_fetch_pc    = 32'h0000_0000;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = ready;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int hits;
        checks   = 0;
        failures = 0;
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        bus.imem_rdata  = '0;
        #2;

        // Reset release with decode always ready: streaming from address 0
        do_reset(1'b1);
        obs_pop_q.delete();
        obs_req_q.delete();
        run(2);
        chk("fill_out_valid_c2", bus.out_valid, 1);
        chk("fill_out_pc_c2", bus.out_pc, 32'h0);
        chk("fill_out_instr_c2", bus.out_instr, 32'h1000_0000);
        run(8);
        chk("fill_req0", req_at(0), 32'h0);
        chk("fill_req1", req_at(1), 32'h4);
        chk("fill_req2", req_at(2), 32'h8);
        for (int i = 0; i < 8; i++) chk("stream_pc", pop_at(i), 32'(i * 4));

        // Decode stalled from reset: FIFO fills to DEPTH and fetch stops
        do_reset(1'b0);
        obs_req_q.delete();
        run(6);
        chk("stall_count", bus.count, DEPTH);
        chk("stall_imem_rd", bus.imem_rd, 0);
        chk("stall_nreq", obs_req_q.size(), 4);
        chk("stall_req3", req_at(3), 32'hC);
        bus.out_ready = 1'b1;
        #1;
        chk("stall_head_pc", bus.out_pc, 32'h0);
        obs_req_q.delete();
        run(3);
        chk("resume_req", req_at(0), 32'h10);

        // Redirect during steady state to an unaligned target
        run(4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0203;
        #1;
        chk("redir_imem_rd", bus.imem_rd, 0);
        cycle();
        bus.redirect = 1'b0;
        #1;
        chk("redir_count", bus.count, 0);
        chk("redir_addr", bus.imem_addr, 32'h200);
        obs_pop_q.delete();
        run(6);
        chk("redir_pop0", pop_at(0), 32'h200);
        chk("redir_pop1", pop_at(1), 32'h204);

        // Back-to-back redirects: only the last target is fetched
        obs_pop_q.delete();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        cycle();
        bus.redirect_pc = 32'h300;
        cycle();
        bus.redirect = 1'b0;
        run(6);
        hits = 0;
        foreach (obs_pop_q[i]) if (obs_pop_q[i] == 32'h100) hits++;
        chk("b2b_no_0x100", hits, 0);
        chk("b2b_first", pop_at(0), 32'h300);

        // PC wrap at the top of the address space
        obs_pop_q.delete();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFB;
        cycle();
        bus.redirect = 1'b0;
        run(6);
        chk("wrap_pop0", pop_at(0), 32'hFFFF_FFF8);
        chk("wrap_pop1", pop_at(1), 32'hFFFF_FFFC);
        chk("wrap_pop2", pop_at(2), 32'h0000_0000);

        // Reset mid-stream with three buffered entries and one in flight
        do_reset(1'b0);
        run(4);
        chk("pre_rst_count", bus.count, 3);
        chk("pre_rst_imem_rd", bus.imem_rd, 0);
        do_reset(1'b1);
        obs_pop_q.delete();
        obs_req_q.delete();
        run(6);
        chk("post_rst_req0", req_at(0), 32'h0);
        chk("post_rst_pop0", pop_at(0), 32'h0);
        chk("post_rst_pop1", pop_at(1), 32'h4);

        // Random decode back-pressure and redirects
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.redirect  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                bus.redirect_pc = 32'($urandom_range(0, 4095));
            cycle();
        end
        bus.redirect = 1'b0;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
